// File: rtl/ts_column_ctrl_if.sv
// Command/response handshake bundle for the column controller.
// master: issues commands and takes responses; slave: the controller.
interface ts_column_ctrl_if #(
  parameter int NUM_ROWS = 128
);
  localparam int AW = $clog2(NUM_ROWS);

  logic                cmd_valid;
  logic                cmd_ready;
  logic [1:0]          cmd_op;
  logic [AW-1:0]       cmd_addr;
  logic                cmd_wdata;
  logic [NUM_ROWS-1:0] cmd_act;
  logic                rsp_valid;
  logic                rsp_ready;
  logic [3:0]          rsp_data;
  logic                rsp_err;

  modport master (
    output cmd_valid, cmd_op, cmd_addr,
    output cmd_wdata, cmd_act, rsp_ready,
    input  cmd_ready, rsp_valid,
    input  rsp_data, rsp_err
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_addr,
    input  cmd_wdata, cmd_act, rsp_ready,
    output cmd_ready, rsp_valid,
    output rsp_data, rsp_err
  );
endinterface

// File: rtl/ts_column_ctrl.sv
// Column sequencer: SRAM write/read and MAC (reset, drive, ADC convert).
// Ports: CLK/RST, bus (cmd/rsp handshake), row selects, SRAM/ADC controls.
module ts_column_ctrl #(
  parameter int SETTLE_CYCLES = 4,
  parameter int NUM_ROWS      = 128
) (
  input  logic                CLK,
  input  logic                RST,
  ts_column_ctrl_if.slave     bus,
  output logic [NUM_ROWS-1:0] VDR_SEL,
  output logic [NUM_ROWS-1:0] VDR_SELB,
  output logic [NUM_ROWS-1:0] VSS_SEL,
  output logic [NUM_ROWS-1:0] VSS_SELB,
  output logic [NUM_ROWS-1:0] VRST_SEL,
  output logic [NUM_ROWS-1:0] VRST_SELB,
  output logic [NUM_ROWS-1:0] WL,
  output logic                PCH,
  output logic                WRITE,
  output logic                WR_DATA,
  output logic                CSEL,
  output logic                SAEN,
  input  logic                SA_OUT,
  input  logic [3:0]          ADC_OUT,
  output logic                NF,
  output logic                NFB,
  output logic                M2A,
  output logic                M2AB,
  output logic                R2A,
  output logic                R2AB
);
  localparam int AW = $clog2(NUM_ROWS);
  // A zero settle count still gets one drive cycle.
  localparam int S  = (SETTLE_CYCLES < 1) ? 1 : SETTLE_CYCLES;
  localparam int CW = (S > 1) ? $clog2(S) : 1;
  localparam logic [NUM_ROWS-1:0] ONE = NUM_ROWS'(1);

  typedef enum logic [2:0] {
    IDLE, WR, RD_PCH, RD_SENSE,
    MAC_RST, MAC_DRV, MAC_CONV, RESP
  } state_e;

  state_e              state_q, state_d;
  logic [1:0]          op_q, op_d;
  logic [AW-1:0]       addr_q, addr_d;
  logic                wdata_q, wdata_d;
  logic [NUM_ROWS-1:0] act_q, act_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [3:0]          rdat_q, rdat_d;
  logic                rerr_q, rerr_d;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      op_q    <= '0;
      addr_q  <= '0;
      wdata_q <= 1'b0;
      act_q   <= '0;
      cnt_q   <= '0;
      rdat_q  <= '0;
      rerr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      act_q   <= act_d;
      cnt_q   <= cnt_d;
      rdat_q  <= rdat_d;
      rerr_q  <= rerr_d;
    end
  end

  assign bus.cmd_ready = (state_q == IDLE) & ~RST;
  assign bus.rsp_valid = (state_q == RESP);
  assign bus.rsp_data  = (state_q == RESP) ? rdat_q : 4'd0;
  assign bus.rsp_err   = (state_q == RESP) & rerr_q;

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    act_d   = act_q;
    cnt_d   = cnt_q;
    rdat_d  = rdat_q;
    rerr_d  = rerr_q;
    case (state_q)
      IDLE: begin
        if (bus.cmd_valid) begin
          op_d    = bus.cmd_op;
          addr_d  = bus.cmd_addr;
          wdata_d = bus.cmd_wdata;
          act_d   = bus.cmd_act;
          rdat_d  = 4'd0;
          rerr_d  = 1'b0;
          unique case (1'b1)
            bus.cmd_op == 2'b00: state_d = WR;
            bus.cmd_op == 2'b01: state_d = RD_PCH;
            bus.cmd_op == 2'b10: state_d = MAC_RST;
            default: begin
              state_d = RESP;
              rerr_d  = 1'b1;
            end
          endcase
        end
      end
      WR:     state_d = RESP;
      RD_PCH: state_d = RD_SENSE;
      RD_SENSE: begin
        rdat_d  = {3'b000, SA_OUT};
        state_d = RESP;
      end
      MAC_RST: begin
        cnt_d   = CW'(S - 1);
        state_d = MAC_DRV;
      end
      MAC_DRV: begin
        if (cnt_q == '0) state_d = MAC_CONV;
        else             cnt_d   = cnt_q - CW'(1);
      end
      MAC_CONV: begin
        rdat_d  = ADC_OUT;
        state_d = RESP;
      end
      RESP: if (bus.rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    VDR_SEL  = '0;
    VSS_SEL  = '0;
    VRST_SEL = '0;
    WL       = '0;
    PCH      = 1'b0;
    WRITE    = 1'b0;
    WR_DATA  = 1'b0;
    CSEL     = 1'b0;
    SAEN     = 1'b0;
    NF       = 1'b0;
    M2A      = 1'b0;
    R2A      = 1'b0;
    case (state_q)
      WR: begin
        WL      = ONE << addr_q;
        PCH     = 1'b1;
        WRITE   = 1'b1;
        WR_DATA = wdata_q;
      end
      RD_PCH, RD_SENSE: begin
        WL   = ONE << addr_q;
        PCH  = 1'b1;
        CSEL = 1'b1;
        SAEN = (state_q == RD_SENSE);
      end
      MAC_RST: begin
        VRST_SEL = '1;
        R2A      = 1'b1;
      end
      MAC_DRV, MAC_CONV: begin
        VDR_SEL = act_q;
        VSS_SEL = ~act_q;
        M2A     = (state_q == MAC_DRV);
        NF      = (state_q == MAC_CONV);
      end
      default: ;
    endcase
  end

  assign VDR_SELB  = ~VDR_SEL;
  assign VSS_SELB  = ~VSS_SEL;
  assign VRST_SELB = ~VRST_SEL;
  assign NFB       = ~NF;
  assign M2AB      = ~M2A;
  assign R2AB      = ~R2A;
endmodule

// File: tb/tb_ts_column_ctrl.sv
// Bench for ts_column_ctrl: scoreboarded responses plus per-cycle checks.
// Tasks per scenario, run in sequence from one initial block.
module tb_ts_column_ctrl;
  logic         clk = 1'b0;
  logic         rst;
  logic [127:0] vdr, vdrb, vss, vssb, vrst, vrstb, wl;
  logic         pch, wr, wrd, csel, saen;
  logic         sa_out;
  logic [3:0]   adc;
  logic         nf, nfb, m2a, m2ab, r2a, r2ab;
  int           tests = 0;
  int           fails = 0;
  logic [4:0]   exp_q[$];
  logic [127:0] one = 128'd1;

  ts_column_ctrl_if #(.NUM_ROWS(128)) bus ();

  ts_column_ctrl #(
    .SETTLE_CYCLES(4),
    .NUM_ROWS(128)
  ) dut (
    .CLK(clk), .RST(rst), .bus(bus.slave),
    .VDR_SEL(vdr), .VDR_SELB(vdrb),
    .VSS_SEL(vss), .VSS_SELB(vssb),
    .VRST_SEL(vrst), .VRST_SELB(vrstb),
    .WL(wl), .PCH(pch), .WRITE(wr),
    .WR_DATA(wrd), .CSEL(csel), .SAEN(saen),
    .SA_OUT(sa_out), .ADC_OUT(adc),
    .NF(nf), .NFB(nfb), .M2A(m2a),
    .M2AB(m2ab), .R2A(r2a), .R2AB(r2ab)
  );

  always #5 clk = ~clk;

  // Called at a negedge in IDLE; returns at the negedge of T+1.
  task automatic issue(input logic [1:0] op,
                       input logic [6:0] addr,
                       input logic wd,
                       input logic [127:0] act,
                       input logic [4:0] exp);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_addr  = addr;
    bus.cmd_wdata = wd;
    bus.cmd_act   = act;
    tests++;
    if (bus.cmd_ready !== 1'b1) begin
      fails++;
      $display("FAIL issue_ready: cmd_ready=%b need 1",
               bus.cmd_ready);
    end
    exp_q.push_back(exp);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
  endtask

  task automatic get_resp(input string nm, input int max_wait);
    logic [4:0] e;
    int n;
    n = 0;
    while (bus.rsp_valid !== 1'b1 && n < max_wait) begin
      @(negedge clk);
      n++;
    end
    tests++;
    if (bus.rsp_valid !== 1'b1 || exp_q.size() == 0) begin
      fails++;
      $display("FAIL %s: rsp_valid=%b pending=%0d need 1/1",
               nm, bus.rsp_valid, exp_q.size());
    end else begin
      e = exp_q.pop_front();
      if ({bus.rsp_err, bus.rsp_data} !== e) begin
        fails++;
        $display("FAIL %s: err,data=%b need %b", nm,
                 {bus.rsp_err, bus.rsp_data}, e);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    tests++;
    if (bus.cmd_ready !== 1'b0 || bus.rsp_valid !== 1'b0 ||
        {vdr, vss, vrst, wl} !== '0 ||
        {vdrb, vssb, vrstb} !== '1 ||
        {pch, wr, wrd, csel, saen, nf, m2a, r2a} !== 8'd0 ||
        {nfb, m2ab, r2ab} !== 3'b111) begin
      fails++;
      $display("FAIL reset_idle: ready=%b valid=%b ctl=%b",
               bus.cmd_ready, bus.rsp_valid,
               {pch, wr, wrd, csel, saen, nf, m2a, r2a});
    end
    rst = 1'b0;
    @(negedge clk);
    tests++;
    if (bus.cmd_ready !== 1'b1) begin
      fails++;
      $display("FAIL reset_release: cmd_ready=%b need 1",
               bus.cmd_ready);
    end
  endtask

  task automatic test_write(input logic [6:0] a, input logic d);
    bus.rsp_ready = 1'b1;
    issue(2'b00, a, d, '0, 5'd0);
    tests++;
    if (wl !== (one << a) ||
        {pch, wr, wrd, csel, saen} !== {2'b11, d, 2'b00} ||
        bus.rsp_valid !== 1'b0) begin
      fails++;
      $display("FAIL write_t1: wl=%h ctl=%b need wl=%h ctl=%b",
               wl, {pch, wr, wrd, csel, saen}, one << a,
               {2'b11, d, 2'b00});
    end
    @(negedge clk);
    tests++;
    if (wl !== '0 || bus.cmd_ready !== 1'b0) begin
      fails++;
      $display("FAIL write_t2: wl=%h ready=%b need 0/0",
               wl, bus.cmd_ready);
    end
    get_resp("write_rsp", 0);
    @(negedge clk);
  endtask

  task automatic test_read(input logic [6:0] a, input logic sa);
    bus.rsp_ready = 1'b1;
    sa_out = ~sa;
    issue(2'b01, a, 1'b0, '0, {4'b0000, sa});
    tests++;
    if (wl !== (one << a) ||
        {pch, wr, csel, saen} !== 4'b1010) begin
      fails++;
      $display("FAIL read_t1: wl=%h ctl=%b need wl=%h ctl=1010",
               wl, {pch, wr, csel, saen}, one << a);
    end
    @(negedge clk);
    tests++;
    if (wl !== (one << a) ||
        {pch, wr, csel, saen} !== 4'b1011) begin
      fails++;
      $display("FAIL read_t2: wl=%h ctl=%b need ctl=1011",
               wl, {pch, wr, csel, saen});
    end
    sa_out = sa;
    @(negedge clk);
    sa_out = ~sa;
    tests++;
    if (saen !== 1'b0 || wl !== '0) begin
      fails++;
      $display("FAIL read_t3: saen=%b wl=%h need 0/0", saen, wl);
    end
    get_resp("read_rsp", 0);
    @(negedge clk);
  endtask

  task automatic test_mac(input logic [127:0] act,
                          input logic [3:0] code);
    bus.rsp_ready = 1'b1;
    adc = ~code;
    issue(2'b10, 7'd0, 1'b0, act, {1'b0, code});
    tests++;
    if (vrst !== '1 || vrstb !== '0 || vdr !== '0 ||
        {r2a, r2ab, m2a, nf} !== 4'b1000) begin
      fails++;
      $display("FAIL mac_rst: vrst=%h vdr=%h ph=%b need ph=1000",
               vrst, vdr, {r2a, r2ab, m2a, nf});
    end
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      tests++;
      if (vdr !== act || vss !== ~act || vdrb !== ~act ||
          vssb !== act || vrst !== '0 ||
          {m2a, m2ab, nf, r2a} !== 4'b1000) begin
        fails++;
        $display("FAIL mac_drv%0d: vdr=%h ph=%b need vdr=%h",
                 c, vdr, {m2a, m2ab, nf, r2a}, act);
      end
    end
    @(negedge clk);
    tests++;
    if (vdr !== act || vss !== ~act ||
        {nf, nfb, m2a, r2a} !== 4'b1000) begin
      fails++;
      $display("FAIL mac_conv: vdr=%h ph=%b need vdr=%h ph=1000",
               vdr, {nf, nfb, m2a, r2a}, act);
    end
    adc = code;
    @(negedge clk);
    adc = ~code;
    tests++;
    if (vdr !== '0 || vss !== '0 || nf !== 1'b0) begin
      fails++;
      $display("FAIL mac_resp_idle: vdr=%h nf=%b need 0", vdr, nf);
    end
    get_resp("mac_rsp", 0);
    @(negedge clk);
  endtask

  task automatic test_illegal();
    bus.rsp_ready = 1'b1;
    issue(2'b11, 7'd3, 1'b1, '1, 5'b10000);
    tests++;
    if ({vdr, vss, vrst, wl} !== '0 ||
        {pch, wr, wrd, csel, saen, nf, m2a, r2a} !== 8'd0) begin
      fails++;
      $display("FAIL illegal_quiet: wl=%h ctl=%b need 0",
               wl, {pch, wr, wrd, csel, saen, nf, m2a, r2a});
    end
    get_resp("illegal_rsp", 0);
    @(negedge clk);
  endtask

  task automatic test_stall();
    bus.rsp_ready = 1'b0;
    issue(2'b01, 7'd9, 1'b0, '0, 5'b00001);
    @(negedge clk);
    sa_out = 1'b1;
    @(negedge clk);
    sa_out = 1'b0;
    get_resp("stall_rsp", 0);
    for (int c = 0; c < 10; c++) begin
      bus.cmd_valid = 1'b1;
      bus.cmd_op    = 2'b00;
      bus.cmd_addr  = 7'd1;
      @(negedge clk);
      tests++;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== 4'd1 ||
          bus.rsp_err !== 1'b0 || bus.cmd_ready !== 1'b0 ||
          wl !== '0) begin
        fails++;
        $display("FAIL stall%0d: v=%b d=%h e=%b rdy=%b need 1/1/0/0",
                 c, bus.rsp_valid, bus.rsp_data,
                 bus.rsp_err, bus.cmd_ready);
      end
    end
    bus.cmd_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    tests++;
    if (bus.rsp_valid !== 1'b0 || bus.cmd_ready !== 1'b1) begin
      fails++;
      $display("FAIL stall_release: v=%b rdy=%b need 0/1",
               bus.rsp_valid, bus.cmd_ready);
    end
  endtask

  task automatic test_reset_mid_mac();
    bus.rsp_ready = 1'b1;
    issue(2'b10, 7'd0, 1'b0, 128'hF0, 5'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    exp_q.delete();
    tests++;
    if ({vdr, vss, vrst} !== '0 || {vdrb, vssb, vrstb} !== '1 ||
        bus.rsp_valid !== 1'b0 || bus.cmd_ready !== 1'b0 ||
        {m2a, nf, r2a} !== 3'b000) begin
      fails++;
      $display("FAIL rst_mac: vdr=%h v=%b rdy=%b need 0/0/0",
               vdr, bus.rsp_valid, bus.cmd_ready);
    end
    rst = 1'b0;
    @(negedge clk);
    tests++;
    if (bus.cmd_ready !== 1'b1 || vdr !== '0) begin
      fails++;
      $display("FAIL rst_mac_release: rdy=%b vdr=%h need 1/0",
               bus.cmd_ready, vdr);
    end
  endtask

  task automatic test_back_to_back();
    logic [6:0] a;
    bus.rsp_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      a = 7'(k * 63 + k / 2);
      issue(2'b00, a, k[0], '0, 5'd0);
      tests++;
      if (wl !== (one << a) || wrd !== k[0]) begin
        fails++;
        $display("FAIL b2b_wl%0d: wl=%h wrd=%b need %h/%b",
                 k, wl, wrd, one << a, k[0]);
      end
      @(negedge clk);
      get_resp("b2b_rsp", 0);
      @(negedge clk);
    end
  endtask

  initial begin
    rst           = 1'b1;
    sa_out        = 1'b0;
    adc           = 4'd0;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 2'b00;
    bus.cmd_addr  = '0;
    bus.cmd_wdata = 1'b0;
    bus.cmd_act   = '0;
    bus.rsp_ready = 1'b0;
    test_reset();
    test_write(7'd5, 1'b1);
    test_write(7'd127, 1'b0);
    test_read(7'd5, 1'b1);
    test_read(7'd0, 1'b0);
    test_mac(128'hF, 4'hA);
    test_mac('0, 4'h3);
    test_mac('1, 4'hF);
    test_illegal();
    test_stall();
    test_reset_mid_mac();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
